// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one shared memory port; data wins ties.
// Optional access timeout is built when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_mask,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyD} state_e;

  state_e state_q;
  logic   busy;
  logic   timeout;

  assign busy = (state_q != StIdle);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;

  // Fires on the last permitted BUSY cycle; a real response in that cycle takes precedence.
  assign timeout = busy && !mem_valid && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!busy) begin
      cnt_q <= '0;
    end else if (!mem_valid) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  assign if_valid  = (state_q == StBusyIf) && (mem_valid || timeout);
  assign d_valid   = (state_q == StBusyD) && (mem_valid || timeout);
  assign if_rdata  = ((state_q == StBusyIf) && mem_valid) ? mem_rdata : 32'h0;
  assign d_rdata   = ((state_q == StBusyD) && mem_valid) ? mem_rdata : 32'h0;
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;
  assign err       = timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_mask  <= 4'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (d_req) begin
            state_q   <= StBusyD;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_mask  <= d_mask;
          end else if (if_req) begin
            state_q   <= StBusyIf;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= 32'h0;
            mem_mask  <= 4'hF;
          end
        end
        StBusyIf, StBusyD: begin
          if (mem_valid || timeout) begin
            state_q <= StIdle;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT_CYCLES = 4).
// Timeout checks follow the MEM_ARB_TIMEOUT_EN build setting.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_mask;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        stall_if;
  logic        stall_mem;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_mask   (d_mask),
    .d_rdata  (d_rdata),
    .d_valid  (d_valid),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_mask (mem_mask),
    .mem_rdata(mem_rdata),
    .mem_valid(mem_valid),
    .stall_if (stall_if),
    .stall_mem(stall_mem),
    .err      (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change just after a rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b1;
    if_req    = 1'b0;
    if_addr   = 32'h0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = 32'h0;
    d_wdata   = 32'h0;
    d_mask    = 4'h0;
    mem_rdata = 32'h0;
    mem_valid = 1'b0;
    #3 rst_n  = 1'b0;
    #1;
    check_eq("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_mask", {28'h0, mem_mask}, 32'h0);
    check_eq("rst_err", {31'h0, err}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // mem_valid while idle is ignored
    mem_valid = 1'b1;
    mem_rdata = 32'h1111_2222;
    smp();
    check_eq("idle_if_valid", {31'h0, if_valid}, 32'h0);
    check_eq("idle_d_valid", {31'h0, d_valid}, 32'h0);
    check_eq("idle_if_rdata", if_rdata, 32'h0);
    tick();
    mem_valid = 1'b0;
    smp();
    check_eq("idle_mem_req", {31'h0, mem_req}, 32'h0);

    // Single fetch, minimum latency
    tick();
    if_req  = 1'b1;
    if_addr = 32'h100;
    smp();
    check_eq("f_stall_pre", {31'h0, stall_if}, 32'h1);
    check_eq("f_mem_req_pre", {31'h0, mem_req}, 32'h0);
    tick();
    mem_valid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    smp();
    check_eq("f_mem_req", {31'h0, mem_req}, 32'h1);
    check_eq("f_mem_addr", mem_addr, 32'h100);
    check_eq("f_mem_we", {31'h0, mem_we}, 32'h0);
    check_eq("f_mem_mask", {28'h0, mem_mask}, 32'hF);
    check_eq("f_if_valid", {31'h0, if_valid}, 32'h1);
    check_eq("f_if_rdata", if_rdata, 32'hDEAD_BEEF);
    check_eq("f_stall_done", {31'h0, stall_if}, 32'h0);
    tick();
    if_req    = 1'b0;
    mem_valid = 1'b0;
    smp();
    check_eq("f_mem_req_off", {31'h0, mem_req}, 32'h0);
    check_eq("f_if_valid_off", {31'h0, if_valid}, 32'h0);
    check_eq("f_if_rdata_off", if_rdata, 32'h0);

    // Simultaneous requests: data first, then fetch after one idle cycle
    tick();
    if_req  = 1'b1;
    if_addr = 32'h200;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h2004;
    d_wdata = 32'h1234_5678;
    d_mask  = 4'b0011;
    tick();
    mem_valid = 1'b1;
    mem_rdata = 32'hCAFE_0001;
    smp();
    check_eq("pr_mem_we", {31'h0, mem_we}, 32'h1);
    check_eq("pr_mem_mask", {28'h0, mem_mask}, 32'h3);
    check_eq("pr_mem_addr", mem_addr, 32'h2004);
    check_eq("pr_mem_wdata", mem_wdata, 32'h1234_5678);
    check_eq("pr_d_valid", {31'h0, d_valid}, 32'h1);
    check_eq("pr_if_valid", {31'h0, if_valid}, 32'h0);
    check_eq("pr_stall_if", {31'h0, stall_if}, 32'h1);
    check_eq("pr_stall_mem", {31'h0, stall_mem}, 32'h0);
    tick();
    d_req     = 1'b0;
    mem_valid = 1'b0;
    smp();
    check_eq("pr_gap_mem_req", {31'h0, mem_req}, 32'h0);
    tick();
    mem_valid = 1'b1;
    mem_rdata = 32'h0000_00AB;
    smp();
    check_eq("pr_f_mem_req", {31'h0, mem_req}, 32'h1);
    check_eq("pr_f_mem_addr", mem_addr, 32'h200);
    check_eq("pr_f_mem_we", {31'h0, mem_we}, 32'h0);
    check_eq("pr_f_mem_mask", {28'h0, mem_mask}, 32'hF);
    check_eq("pr_f_mem_wdata", mem_wdata, 32'h0);
    check_eq("pr_f_if_rdata", if_rdata, 32'h0000_00AB);
    tick();
    if_req    = 1'b0;
    mem_valid = 1'b0;

    // Slow memory: outputs held for 5 cycles, one d_valid
    tick();
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h3000;
    d_wdata = 32'hA5A5_A5A5;
    d_mask  = 4'hC;
    tick();
    d_addr  = 32'hFFFF_FFFF;
    d_wdata = 32'h0;
    d_mask  = 4'h0;
    for (int i = 0; i < 5; i++) begin
      smp();
      check_eq("sl_mem_addr", mem_addr, 32'h3000);
      check_eq("sl_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
      check_eq("sl_mem_mask", {28'h0, mem_mask}, 32'hC);
      check_eq("sl_mem_req", {31'h0, mem_req}, 32'h1);
      check_eq("sl_stall_mem", {31'h0, stall_mem}, 32'h1);
      check_eq("sl_d_valid", {31'h0, d_valid}, 32'h0);
      tick();
    end
    mem_valid = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    smp();
    check_eq("sl_d_valid_done", {31'h0, d_valid}, 32'h1);
    check_eq("sl_d_rdata", d_rdata, 32'h0BAD_F00D);
    tick();
    d_req     = 1'b0;
    mem_valid = 1'b0;
    smp();
    check_eq("sl_d_valid_off", {31'h0, d_valid}, 32'h0);
    check_eq("sl_stall_off", {31'h0, stall_mem}, 32'h0);

    // Request dropped mid-access still completes
    tick();
    if_req  = 1'b1;
    if_addr = 32'h500;
    tick();
    if_req = 1'b0;
    tick();
    mem_valid = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    smp();
    check_eq("dr_if_valid", {31'h0, if_valid}, 32'h1);
    check_eq("dr_if_rdata", if_rdata, 32'h5555_AAAA);
    tick();
    mem_valid = 1'b0;

    // Asynchronous reset mid-fetch
    tick();
    if_req  = 1'b1;
    if_addr = 32'h400;
    tick();
    smp();
    check_eq("ar_mem_req_busy", {31'h0, mem_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_mem_req_now", {31'h0, mem_req}, 32'h0);
    check_eq("ar_mem_addr_now", mem_addr, 32'h0);
    if_req = 1'b0;
    tick();
    rst_n     = 1'b1;
    mem_valid = 1'b1;
    mem_rdata = 32'h9999_9999;
    smp();
    check_eq("ar_if_valid", {31'h0, if_valid}, 32'h0);
    check_eq("ar_if_rdata", if_rdata, 32'h0);
    tick();
    mem_valid = 1'b0;
    smp();
    check_eq("ar_mem_req_after", {31'h0, mem_req}, 32'h0);

    // Memory never answers
    tick();
    d_req     = 1'b1;
    d_we      = 1'b1;
    d_addr    = 32'h5000;
    d_wdata   = 32'h0000_0042;
    d_mask    = 4'hF;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    for (int i = 0; i < 3; i++) begin
      smp();
      check_eq("to_err_early", {31'h0, err}, 32'h0);
      check_eq("to_d_valid_early", {31'h0, d_valid}, 32'h0);
      tick();
    end
    smp();
`ifdef MEM_ARB_TIMEOUT_EN
    check_eq("to_err", {31'h0, err}, 32'h1);
    check_eq("to_d_valid", {31'h0, d_valid}, 32'h1);
    check_eq("to_d_rdata", d_rdata, 32'h0);
    tick();
    d_req = 1'b0;
    smp();
    check_eq("to_idle_mem_req", {31'h0, mem_req}, 32'h0);
    check_eq("to_err_off", {31'h0, err}, 32'h0);

    // Response on the deadline cycle beats the timeout
    tick();
    d_req = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    mem_valid = 1'b1;
    mem_rdata = 32'h0000_0077;
    smp();
    check_eq("tr_err", {31'h0, err}, 32'h0);
    check_eq("tr_d_valid", {31'h0, d_valid}, 32'h1);
    check_eq("tr_d_rdata", d_rdata, 32'h0000_0077);
    tick();
    d_req     = 1'b0;
    mem_valid = 1'b0;
`else
    check_eq("nt_err", {31'h0, err}, 32'h0);
    check_eq("nt_d_valid", {31'h0, d_valid}, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    smp();
    check_eq("nt_mem_req_held", {31'h0, mem_req}, 32'h1);
    check_eq("nt_err_late", {31'h0, err}, 32'h0);
    check_eq("nt_stall_mem", {31'h0, stall_mem}, 32'h1);
    tick();
    mem_valid = 1'b1;
    mem_rdata = 32'h0000_0033;
    smp();
    check_eq("nt_d_valid_done", {31'h0, d_valid}, 32'h1);
    check_eq("nt_d_rdata", d_rdata, 32'h0000_0033);
    tick();
    d_req     = 1'b0;
    mem_valid = 1'b0;
`endif
    smp();
    check_eq("end_mem_req", {31'h0, mem_req}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
